// File: rtl/output_collector.sv
// output_collector: captures finished output pixels (value + x/y/ch)
// into a small FWFT FIFO and drains them to the host over valid/ready.
//
// Ports:
//   clk, arst_n_in       clock, async active-low reset
//   flush                sync clear of contents and overflow flag
//   in_valid, in_data,
//   in_x, in_y, in_ch    result capture (one-cycle pulse)
//   out_valid, out_ready,
//   out_data, out_x,
//   out_y, out_ch        head entry, valid/ready handshake
//   count, empty, full,
//   almost_full          occupancy status
//   overflow             sticky: a result was dropped
//
// Optional: define OUTPUT_COLLECTOR_RELU_EN to clamp negative
// in_data to zero on the push path.

module output_collector #(
  parameter int DATA_WIDTH        = 32,
  parameter int COORD_WIDTH       = 32,
  parameter int FIFO_DEPTH        = 8,
  parameter int ALMOST_FULL_LEVEL = 6
) (
  input  logic                           clk,
  input  logic                           arst_n_in,
  input  logic                           flush,
  input  logic                           in_valid,
  input  logic [DATA_WIDTH-1:0]          in_data,
  input  logic [COORD_WIDTH-1:0]         in_x,
  input  logic [COORD_WIDTH-1:0]         in_y,
  input  logic [COORD_WIDTH-1:0]         in_ch,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [DATA_WIDTH-1:0]          out_data,
  output logic [COORD_WIDTH-1:0]         out_x,
  output logic [COORD_WIDTH-1:0]         out_y,
  output logic [COORD_WIDTH-1:0]         out_ch,
  output logic [$clog2(FIFO_DEPTH):0]    count,
  output logic                           empty,
  output logic                           full,
  output logic                           almost_full,
  output logic                           overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(ALMOST_FULL_LEVEL);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);

  logic [DATA_WIDTH-1:0]  mem_data [FIFO_DEPTH];
  logic [COORD_WIDTH-1:0] mem_x    [FIFO_DEPTH];
  logic [COORD_WIDTH-1:0] mem_y    [FIFO_DEPTH];
  logic [COORD_WIDTH-1:0] mem_ch   [FIFO_DEPTH];

  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         cnt;
  logic                  ovf;
  logic                  pop;
  logic                  push;
  logic                  push_e;
  logic                  pop_e;
  logic                  drop;
  logic [DATA_WIDTH-1:0] wdata;

  assign count       = cnt;
  assign empty       = (cnt == '0);
  assign full        = (cnt == DEPTH_C);
  assign almost_full = (cnt >= AF_C);
  assign overflow    = ovf;
  assign out_valid   = !empty;

  assign out_data = mem_data[rd_ptr];
  assign out_x    = mem_x[rd_ptr];
  assign out_y    = mem_y[rd_ptr];
  assign out_ch   = mem_ch[rd_ptr];

  // A pop frees a slot on the same edge, so a full FIFO
  // can still accept a push while the host is draining.
  assign pop  = out_valid && out_ready;
  assign push = in_valid && (!full || pop);
  assign drop = in_valid && full && !pop;

  // Flush swallows any coincident push or pop.
  assign push_e = push && !flush;
  assign pop_e  = pop && !flush;

`ifdef OUTPUT_COLLECTOR_RELU_EN
  assign wdata = in_data[DATA_WIDTH-1] ? '0 : in_data;
`else
  assign wdata = in_data;
`endif

  // Storage has no reset; contents are don't-care while empty.
  always_ff @(posedge clk) begin
    if (push_e) begin
      mem_data[wr_ptr] <= wdata;
      mem_x[wr_ptr]    <= in_x;
      mem_y[wr_ptr]    <= in_y;
      mem_ch[wr_ptr]   <= in_ch;
    end
  end

  always_ff @(posedge clk or negedge arst_n_in) begin
    if (!arst_n_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      ovf    <= 1'b0;
    end else begin
      if (push_e) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_e)  rd_ptr <= rd_ptr + PTR_ONE;
      unique case (1'b1)
        (push_e && !pop_e): cnt <= cnt + CNT_ONE;
        (pop_e && !push_e): cnt <= cnt - CNT_ONE;
        default:            cnt <= cnt;
      endcase
      if (drop) ovf <= 1'b1;
    end
  end

endmodule

// File: doc/output_collector.md
Name: output_collector

Overview:
- Sits directly downstream of the convolution controller/MAC datapath.
- Captures each finished output pixel: accumulator value plus its x, y and output-channel coordinates, qualified by the controller's output-valid pulse.
- Buffers results in a small first-word-fall-through FIFO and drains them to the external host over a valid/ready handshake.
- Flags dropped results and provides an almost-full indication for future backpressure.

Parameters:
- DATA_WIDTH, 32, width of the accumulator value.
- COORD_WIDTH, 32, width of each coordinate field (x, y, ch).
- FIFO_DEPTH, 8, number of entries; must be a power of 2 and at least 2.
- ALMOST_FULL_LEVEL, 6, occupancy at or above which almost_full asserts.

Ports:
- clk  input  1  clock
- arst_n_in  input  1  asynchronous reset, active low
- flush  input  1  synchronous clear of FIFO contents and overflow flag
- in_valid  input  1  one-cycle pulse marking a finished output (the controller's output_valid)
- in_data  input  DATA_WIDTH  accumulator result, signed
- in_x  input  COORD_WIDTH  output x coordinate
- in_y  input  COORD_WIDTH  output y coordinate
- in_ch  input  COORD_WIDTH  output channel
- out_valid  output  1  head entry available
- out_ready  input  1  host accepts head entry
- out_data  output  DATA_WIDTH  head data
- out_x  output  COORD_WIDTH  head x coordinate
- out_y  output  COORD_WIDTH  head y coordinate
- out_ch  output  COORD_WIDTH  head channel
- count  output  $clog2(FIFO_DEPTH)+1  current occupancy
- empty  output  1  count == 0
- full  output  1  count == FIFO_DEPTH
- almost_full  output  1  count >= ALMOST_FULL_LEVEL
- overflow  output  1  sticky: a result was dropped

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (clk, arst_n_in).
  - During reset: pointers = 0, count = 0, overflow = 0, out_valid = 0, empty = 1, full = 0, almost_full = 0.
  - Storage array is not reset; out_data, out_x, out_y and out_ch are don't-care while out_valid = 0.
- Storage: entry = {data, x, y, ch}.
  - Write pointer and read pointer are each $clog2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH.
  - count is a separate up/down counter.
- Push: occurs when in_valid = 1 and (full = 0 or pop this cycle). The entry is written at the write pointer on the clock edge, and the write pointer increments.
- Pop: occurs when out_valid = 1 and out_ready = 1. The read pointer increments on the clock edge.
- FWFT output:
  - out_valid = !empty.
  - out_* are driven combinationally from the entry at the read pointer.
  - Latency from a push into an empty FIFO to out_valid = 1 is one cycle (visible the cycle after in_valid).
- Simultaneous push and pop: count unchanged; both pointers advance. This is legal when full (a slot is freed and refilled the same edge) and when count == 1.
- Pop when empty: impossible, because out_valid = 0.
- Overflow: in_valid = 1, full = 1 and no pop → the entry is dropped and overflow is set to 1. overflow stays 1 until flush or reset. FIFO contents are unaffected.
- Flush has priority over push and pop in the same cycle:
  - Next cycle: pointers = 0, count = 0, overflow = 0.
  - A push or pop coincident with flush is discarded (not counted as overflow).
- Handshake rule: while out_valid = 1 and out_ready = 0, out_* are held stable; pushes do not disturb the head entry.
- Reset mid-operation: all state returns to reset values immediately (asynchronous); contents are lost.
- Arithmetic: count increments and decrements without wrap; full and empty are derived from count, not from pointer comparison.

Optional Feature:
- Macro: OUTPUT_COLLECTOR_RELU_EN
- Defined: in_data is treated as signed; a negative value is stored as 0 and non-negative values are stored unchanged. Coordinates are unaffected. The clamp is combinational on the push path and adds no latency.
- Undefined: in_data is stored bit-exact.

Test Plan:
- Reset, then one push (in_data = 32'hFFFF_FFF6 = -10, x = 3, y = 5, ch = 7).
  - Cycle+1: out_valid = 1, count = 1, out_x = 3, out_y = 5, out_ch = 7.
  - out_data = -10 without RELU_EN; 0 with OUTPUT_COLLECTOR_RELU_EN defined.
- out_ready = 0, push 8 entries with data 1..8.
  - full = 1, count = 8; almost_full = 1 from the 6th push onward.
  - out_data stays 1 throughout.
- With FIFO full and out_ready = 0, push data 9.
  - overflow = 1, count = 8.
  - Draining yields 1..8 in order (9 absent); overflow still 1 after draining.
- With FIFO full, assert in_valid (data 9) and out_ready together.
  - count stays 8, overflow = 0.
  - Full drain order is 2..9.
- Push 3 entries and then assert flush together with in_valid.
  - Next cycle: count = 0, empty = 1, out_valid = 0, overflow = 0.
- Pointer wrap: stream 20 entries (data 100..119) with out_ready = 1 continuously.
  - Every value appears on the output exactly once, in order; count never exceeds 1.
  - Deassert arst_n_in mid-stream → out_valid = 0 immediately.
